i2s_tx_audio: RTL

//  Downstream consumer of the 16-bit signed tone samples produced at SAMPLE_RATE by the tone generators.

---
 rtl/audio_pkg.sv | 26 ++
 rtl/sample_fifo2.sv | 67 ++++++
 rtl/i2s_tx_audio.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared types and constants for the I2S audio transmit path.
//   sample_t     : 16-bit signed two's-complement audio sample
//   i2s_state_t  : transmitter FSM state (IDLE / RUN / DRAIN)
//   CLK_FREQ     : nominal system clock in Hz (used for clock generation in the bench)
//   FRAME_BITS   : BCLK periods per I2S frame (two slots)
//   SLOT_BITS    : BCLK periods per channel slot
//   SAMPLE_W     : sample width in bits
// -----------------------------------------------------------------------------
package audio_pkg;

  localparam int CLK_FREQ   = 125_000_000;
  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;
  localparam int SAMPLE_W   = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } i2s_state_t;

endpackage : audio_pkg

// File: rtl/sample_fifo2.sv
// -----------------------------------------------------------------------------
// sample_fifo2
// Two-entry sample FIFO. A push while full and a pop while empty are ignored;
// a push and a pop in the same cycle are both honoured and leave the count
// unchanged. Read data is the head entry, valid whenever o_empty is low.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   i_push       : write i_data (ignored when full)
//   i_data       : sample to write
//   i_pop        : drop the head entry (ignored when empty)
//   o_data       : head entry
//   o_count      : number of stored entries, 0..2
//   o_full       : o_count == 2
//   o_empty      : o_count == 0
// -----------------------------------------------------------------------------
module sample_fifo2 import audio_pkg::*; (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_push,
  input  logic [SAMPLE_W-1:0] i_data,
  input  logic                i_pop,
  output logic [SAMPLE_W-1:0] o_data,
  output logic [1:0]          o_count,
  output logic                o_full,
  output logic                o_empty
);

  sample_t    r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop  && !o_empty;

  // NOTE: storage is deliberately not reset; r_count alone says which entries
  // hold data, so clearing the array would only cost reset routing.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

endmodule : sample_fifo2

// File: rtl/i2s_tx_audio.sv
// -----------------------------------------------------------------------------
// i2s_tx_audio
// Buffers mono 16-bit samples in a 2-entry FIFO and serialises them to an I2S
// DAC (Philips format, 64 BCLK per frame, 32-bit slots, the same sample in the
// left and right slot). BCLK and LRCLK are divided down from clk.
// Parameter:
//   BCLK_HALF_DIV : clk cycles per BCLK half period
// Ports:
//   clk, reset_n  : system clock, asynchronous active-low reset
//   enable        : 1 = run; 0 = stop at the next frame boundary
//   sample_in     : signed sample, accepted when sample_valid && sample_ready
//   sample_valid  : sample_in is valid
//   sample_ready  : FIFO has room
//   bclk          : I2S bit clock
//   lrclk         : I2S word select, 0 = left, 1 = right
//   sdata         : I2S serial data, updated as bclk falls
//   underrun_cnt  : frames started with an empty FIFO, saturating
// Build option:
//   I2S_TX_UNDERRUN_HOLD_EN : on underrun repeat the previous sample instead
//                             of sending silence.
// -----------------------------------------------------------------------------
module i2s_tx_audio import audio_pkg::*; #(
  parameter int BCLK_HALF_DIV = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic [15:0] underrun_cnt
);

  localparam int DIV_W = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(BCLK_HALF_DIV - 1);
  localparam int B_W   = $clog2(FRAME_BITS);
  localparam int K_W   = $clog2(SLOT_BITS);
  localparam int IDX_W = $clog2(SAMPLE_W);

  i2s_state_t     r_state;
  logic [DIV_W-1:0] r_div;
  logic           r_bclk;
  logic           r_lrclk;
  logic           r_sdata;
  logic [B_W-1:0] r_b;
  sample_t        r_shreg;
  logic [15:0]    r_underrun;

  logic           w_push;
  logic           w_pop;
  logic [15:0]    w_fifo_data;
  logic [1:0]     w_fifo_count;
  logic           w_full;
  logic           w_empty;
  logic           w_tc;
  logic           w_fall;
  logic [B_W-1:0] w_b_next;
  logic           w_frame_end;
  logic           w_stop;
  logic           w_start;
  logic           w_load;
  logic           w_underrun;
  logic [K_W-1:0] w_k;
  logic           w_bit;
  sample_t        w_underrun_fill;

  sample_fifo2 u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (sample_in),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_push       = sample_valid && !w_full;
  assign sample_ready = (w_fifo_count != 2'd2);

  // A fall event is the divider terminal count while bclk is high.
  assign w_tc        = (r_div == DIV_TC);
  assign w_fall      = w_tc && r_bclk && (r_state != IDLE);
  assign w_b_next    = r_b + B_W'(1);
  assign w_frame_end = w_fall && (r_b == B_W'(FRAME_BITS - 1));
  // Only a draining transmitter with enable still low stops at the wrap;
  // if enable came back it behaves exactly like RUN.
  assign w_stop      = (r_state == DRAIN) && !enable && w_frame_end;
  // RUN entry doubles as the b == 0 frame load of the first frame.
  assign w_start     = (r_state == IDLE) && enable && !w_empty;
  assign w_load      = w_start || (w_frame_end && !w_stop);
  assign w_pop       = w_load && !w_empty;
  assign w_underrun  = w_frame_end && !w_stop && w_empty;

`ifdef I2S_TX_UNDERRUN_HOLD_EN
  // Last sample taken from the FIFO, replayed on underrun.
  sample_t r_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= '0;
    end else if (w_pop) begin
      r_last <= w_fifo_data;
    end
  end

  assign w_underrun_fill = r_last;
`else
  assign w_underrun_fill = '0;
`endif

  // Slot position k = 1..16 carries the sample MSB first; all other slot
  // positions, including k = 0 (the Philips one-bit delay), are 0.
  always_comb begin
    w_k   = w_b_next[K_W-1:0];
    // NOTE: default first so every path assigns w_bit and no latch is inferred.
    w_bit = 1'b0;
    if ((w_k != '0) && (w_k <= K_W'(SAMPLE_W))) begin
      w_bit = r_shreg[IDX_W'(K_W'(SAMPLE_W) - w_k)];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_div      <= '0;
      r_bclk     <= 1'b0;
      r_lrclk    <= 1'b0;
      r_sdata    <= 1'b0;
      r_b        <= '0;
      r_shreg    <= '0;
      r_underrun <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_div   <= '0;
          r_bclk  <= 1'b0;
          r_lrclk <= 1'b0;
          r_sdata <= 1'b0;
          r_b     <= '0;
          if (w_start) r_state <= RUN;
        end
        RUN, DRAIN: begin
          if (w_tc) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
          end else begin
            r_div  <= r_div + DIV_W'(1);
          end
          if (w_fall) begin
            r_b     <= w_b_next;
            r_lrclk <= w_b_next[K_W];
            r_sdata <= w_bit;
          end
          if (w_stop)      r_state <= IDLE;
          else if (enable) r_state <= RUN;
          else             r_state <= DRAIN;
        end
        default: r_state <= IDLE;
      endcase

      if (w_load) begin
        r_shreg <= w_empty ? w_underrun_fill : sample_t'(w_fifo_data);
      end
      if (w_underrun && (r_underrun != 16'hFFFF)) begin
        r_underrun <= r_underrun + 16'd1;
      end
    end
  end

  assign bclk         = r_bclk;
  assign lrclk        = r_lrclk;
  assign sdata        = r_sdata;
  assign underrun_cnt = r_underrun;

endmodule : i2s_tx_audio
